score_display: RTL and testbench

- Drives the Basys3 4-digit 7-segment display with the game score as a decimal number.
- Converts the 16-bit binary score to four BCD digits, saturating at 9999.
- Time-multiplexes one digit per slow-clock cycle and decodes it to segment patterns.
- Sits at the top level between the score counter and the board's an/seg pins, clocked by the slow scan clock (~1 kHz).

---
 rtl/score_display.sv | 114 +++++++++++
 tb/tb_score_display.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/score_display.sv
// Purpose : shows a 16-bit binary score as four decimal digits on a multiplexed 7-segment display.
// Latency : registered outputs; a new score appears on the next scan slot of each digit (<= 4 clocks).
// Backpres: none; score is sampled live every clock and the scan never stalls.
//
// Ports:
//   slw_clk   - scan clock (~1 kHz), all state on its rising edge
//   rst       - synchronous active-high reset
//   score     - unsigned binary score, saturated to MAX_DISPLAY for display
//   an_cntrl  - digit enables, bit 0 = ones ... bit 3 = thousands
//   seg_cntrl - segments a..g on bits 0..6, no decimal point
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank leading zero digits, ones never blanked).
module score_display #(
  parameter int ACTIVE_LOW  = 1,
  parameter int MAX_DISPLAY = 9999
) (
  input  logic        slw_clk,
  input  logic        rst,
  input  logic [15:0] score,
  output logic [3:0]  an_cntrl,
  output logic [6:0]  seg_cntrl
);

  // 9999 fits in 14 bits, so the saturated value and BCD path are kept at that width.
  localparam logic [13:0] MAX14   = 14'(MAX_DISPLAY);
  localparam logic        POL_INV = (ACTIVE_LOW == 0);
  localparam logic [3:0]  AN_OFF  = 4'b1111 ^ {4{POL_INV}};
  localparam logic [6:0]  SEG_OFF = 7'b1111111 ^ {7{POL_INV}};

  logic [1:0]  idx_q, idx_d;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;

  logic [13:0] sat;
  logic [15:0] bcd;
  logic [3:0]  blank;
  logic [3:0]  dig;
  logic [3:0]  an_lo;
  logic [6:0]  seg_lo;

  // Segment patterns in active-low form.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  assign sat = (score > {2'b00, MAX14}) ? MAX14 : score[13:0];

  // Double-dabble: add 3 to any BCD nibble >= 5 before each left shift.
  // Input is <= 9999, so the 16-bit BCD result never overflows.
  always_comb begin
    bcd = '0;
    for (int b = 13; b >= 0; b--) begin
      for (int k = 0; k < 4; k++) begin
        if (bcd[4*k +: 4] >= 4'd5) begin
          bcd[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
        end
      end
      bcd = {bcd[14:0], sat[b]};
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is blanked only if it and every more significant digit are zero.
  always_comb begin
    blank    = 4'b0000;
    blank[3] = (bcd[15:12] == 4'd0);
    blank[2] = blank[3] && (bcd[11:8] == 4'd0);
    blank[1] = blank[2] && (bcd[7:4] == 4'd0);
    blank[0] = 1'b0;
  end
`else
  assign blank = 4'b0000;
`endif

  always_comb begin
    idx_d  = idx_q + 2'd1;
    dig    = bcd[{idx_q, 2'b00} +: 4];
    an_lo  = ~(4'b0001 << idx_q);
    seg_lo = seg_decode(dig);
    if (blank[idx_q]) begin
      an_lo  = 4'b1111;
      seg_lo = 7'b1111111;
    end
    an_d  = an_lo ^ {4{POL_INV}};
    seg_d = seg_lo ^ {7{POL_INV}};
  end

  always_ff @(posedge slw_clk) begin
    if (rst) begin
      idx_q <= 2'd0;
      an_q  <= AN_OFF;
      seg_q <= SEG_OFF;
    end else begin
      idx_q <= idx_d;
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign an_cntrl  = an_q;
  assign seg_cntrl = seg_q;

endmodule

// File: tb/tb_score_display.sv
module tb_score_display;

  logic        slw_clk = 1'b0;
  logic        rst     = 1'b1;
  logic [15:0] score   = 16'd0;
  logic [3:0]  an_lo_o, an_hi_o;
  logic [6:0]  seg_lo_o, seg_hi_o;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] m_idx = 2'd0;

  score_display #(.ACTIVE_LOW(1), .MAX_DISPLAY(9999)) dut (
    .slw_clk(slw_clk), .rst(rst), .score(score),
    .an_cntrl(an_lo_o), .seg_cntrl(seg_lo_o)
  );

  score_display #(.ACTIVE_LOW(0), .MAX_DISPLAY(9999)) dut_hi (
    .slw_clk(slw_clk), .rst(rst), .score(score),
    .an_cntrl(an_hi_o), .seg_cntrl(seg_hi_o)
  );

  always #5 slw_clk = ~slw_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] ref_seg(input int d);
    logic [6:0] tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    return tbl[d];
  endfunction

  // Drive one clock of stimulus, predict the output of the coming edge, then compare.
  task automatic drive(input logic r, input logic [15:0] sc, input string tag);
    exp_t e, got_e;
    int   s;
    int   d[4];
    logic [3:0] blk;
    rst   = r;
    score = sc;
    if (r) begin
      e.an  = 4'b1111;
      e.seg = 7'b1111111;
      m_idx = 2'd0;
    end else begin
      s    = (int'(sc) > 9999) ? 9999 : int'(sc);
      d[0] = s % 10;
      d[1] = (s / 10) % 10;
      d[2] = (s / 100) % 10;
      d[3] = s / 1000;
      blk  = 4'b0000;
`ifdef LEADING_ZERO_BLANK_EN
      if (s < 1000) blk[3] = 1'b1;
      if (s < 100)  blk[2] = 1'b1;
      if (s < 10)   blk[1] = 1'b1;
`endif
      e.an  = 4'b1111;
      e.an[m_idx] = 1'b0;
      e.seg = ref_seg(d[m_idx]);
      if (blk[m_idx]) begin
        e.an  = 4'b1111;
        e.seg = 7'b1111111;
      end
      m_idx = m_idx + 2'd1;
    end
    sb.push_back(e);
    @(posedge slw_clk);
    #1;
    got_e = sb.pop_front();
    check({tag, ".an"},     {28'd0, an_lo_o},  {28'd0, got_e.an});
    check({tag, ".seg"},    {25'd0, seg_lo_o}, {25'd0, got_e.seg});
    check({tag, ".an_hi"},  {28'd0, an_hi_o},  {28'd0, ~got_e.an});
    check({tag, ".seg_hi"}, {25'd0, seg_hi_o}, {25'd0, ~got_e.seg});
  endtask

  initial begin
    // Reset held for three edges.
    for (int i = 0; i < 3; i++) drive(1'b1, 16'd4702, "reset_hold");

    // Score 4702 walkthrough with literal expectations.
    drive(1'b0, 16'd4702, "s4702_e1");
    check("lit_e1_an", {28'd0, an_lo_o}, 32'b1110); check("lit_e1_seg", {25'd0, seg_lo_o}, 32'b0100100);
    drive(1'b0, 16'd4702, "s4702_e2");
    check("lit_e2_an", {28'd0, an_lo_o}, 32'b1101); check("lit_e2_seg", {25'd0, seg_lo_o}, 32'b1000000);
    drive(1'b0, 16'd4702, "s4702_e3");
    check("lit_e3_an", {28'd0, an_lo_o}, 32'b1011); check("lit_e3_seg", {25'd0, seg_lo_o}, 32'b1111000);
    drive(1'b0, 16'd4702, "s4702_e4");
    check("lit_e4_an", {28'd0, an_lo_o}, 32'b0111); check("lit_e4_seg", {25'd0, seg_lo_o}, 32'b0011001);
    drive(1'b0, 16'd4702, "s4702_e5");
    check("lit_e5_an", {28'd0, an_lo_o}, 32'b1110); check("lit_e5_seg", {25'd0, seg_lo_o}, 32'b0100100);

    // Realign to slot 0 via reset, then saturation and zero.
    drive(1'b1, 16'd0, "rst_a");
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 16'd65535, "s65535");
      check("lit_9999_seg", {25'd0, seg_lo_o}, 32'b0010000);
    end
    for (int i = 0; i < 4; i++) drive(1'b0, 16'd0, "s0");
    drive(1'b0, 16'd0, "s0_slot0");
    check("lit_zero_slot0", {25'd0, seg_lo_o}, 32'b1000000);

    // Saturation boundaries.
    for (int i = 0; i < 4; i++) drive(1'b0, 16'd9999, "s9999");
    for (int i = 0; i < 4; i++) drive(1'b0, 16'd10000, "s10000");
    for (int i = 0; i < 4; i++) drive(1'b0, 16'd42, "s42");
    for (int i = 0; i < 4; i++) drive(1'b0, 16'd305, "s305");

    // Mid-scan change 1234 -> 5678.
    drive(1'b1, 16'd1234, "rst_b");
    drive(1'b0, 16'd1234, "s1234_a");
    drive(1'b0, 16'd1234, "s1234_b");
    for (int i = 0; i < 6; i++) drive(1'b0, 16'd5678, "s5678");

    // Reset asserted at scan index 2.
    drive(1'b1, 16'd1234, "rst_c");
    drive(1'b0, 16'd1234, "mid_a");
    drive(1'b0, 16'd1234, "mid_b");
    check("idx_at_2", {30'd0, m_idx}, 32'd2);
    drive(1'b1, 16'd1234, "mid_rst");
    check("lit_midrst_an", {28'd0, an_lo_o}, 32'b1111);
    drive(1'b0, 16'd1234, "mid_restart");
    check("lit_restart_an", {28'd0, an_lo_o}, 32'b1110);

    // Random scores, changing each cycle.
    for (int i = 0; i < 80; i++) drive(1'b0, 16'($urandom_range(0, 65535)), "rand");
    for (int i = 0; i < 40; i++) drive(1'b0, 16'($urandom_range(0, 120)), "rand_small");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
